// File: rtl/store_issue_unit_pkg.sv
// Shared types for the store issue path: store op encodings and the formatted
// bus request carried through the store FIFO.
package store_issue_unit_pkg;

  typedef enum logic [2:0] {
    ST_OP_SB  = 3'd0,
    ST_OP_SH  = 3'd1,
    ST_OP_SW  = 3'd2,
    ST_OP_SWL = 3'd3,
    ST_OP_SWR = 3'd4
  } st_op_e;

  // One FIFO entry: addr + wstrb + wdata + size.
  localparam int ST_REQ_WD = 32 + 4 + 32 + 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [1:0]  size;
  } st_req_t;

endpackage

// File: rtl/store_issue_unit_if.sv
// Write side of the SRAM-like data bus (req/addr_ok/data_ok handshake).
interface store_issue_unit_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok);
  modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok);
endinterface

// File: rtl/store_issue_unit_store_fmt.sv
// Combinational store formatter: turns op/address/register value into the
// lane-aligned bus request, and flags illegal ops and misaligned SH/SW.
module store_fmt
  import store_issue_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output st_req_t     req,
  output logic        legal,
  output logic        misaligned
);

  logic [1:0] a;
  assign a = addr[1:0];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    req        = '0;
    req.addr   = addr;
    legal      = 1'b1;
    misaligned = 1'b0;
    case (op)
      ST_OP_SB: begin
        req.wstrb = 4'b0001 << a;
        req.wdata = {4{data[7:0]}};
        req.size  = 2'd0;
      end
      ST_OP_SH: begin
        req.wstrb  = a[1] ? 4'b1100 : 4'b0011;
        req.wdata  = {2{data[15:0]}};
        req.size   = 2'd1;
        misaligned = a[0];
      end
      ST_OP_SW: begin
        req.wstrb  = 4'b1111;
        req.wdata  = data;
        req.size   = 2'd2;
        misaligned = (a != 2'd0);
      end
      ST_OP_SWL: begin
        // SWL writes the high-order bytes of rt into the low end of the aligned word.
        req.addr = {addr[31:2], 2'b00};
        case (a)
          2'd0:    begin req.wstrb = 4'b0001; req.wdata = data >> 24; req.size = 2'd0; end
          2'd1:    begin req.wstrb = 4'b0011; req.wdata = data >> 16; req.size = 2'd1; end
          2'd2:    begin req.wstrb = 4'b0111; req.wdata = data >> 8;  req.size = 2'd2; end
          default: begin req.wstrb = 4'b1111; req.wdata = data;       req.size = 2'd2; end
        endcase
      end
      ST_OP_SWR: begin
        case (a)
          2'd0:    begin req.wstrb = 4'b1111; req.wdata = data;       req.size = 2'd2; end
          2'd1:    begin req.wstrb = 4'b1110; req.wdata = data << 8;  req.size = 2'd2; end
          2'd2:    begin req.wstrb = 4'b1100; req.wdata = data << 16; req.size = 2'd1; end
          default: begin req.wstrb = 4'b1000; req.wdata = data << 24; req.size = 2'd0; end
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_issue_unit.sv
// Store issue unit: formats stores from EX, queues them in a FIFO and issues
// them on the data bus while bounding the number of outstanding writes.
module store_issue_unit
  import store_issue_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               st_valid,
  output logic               st_ready,
  input  logic [2:0]         st_op,
  input  logic [31:0]        st_addr,
  input  logic [31:0]        st_data,
  output logic               st_ade,
  output logic               st_empty,
  store_issue_unit_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  st_req_t fmt_req;
  logic    fmt_legal;
  logic    fmt_misaligned;

  store_fmt u_fmt (
    .op         (st_op),
    .addr       (st_addr),
    .data       (st_data),
    .req        (fmt_req),
    .legal      (fmt_legal),
    .misaligned (fmt_misaligned)
  );

  st_req_t       mem [DEPTH];
  st_req_t       head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic          full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          issue;
  logic          retire;

  assign full       = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign st_ready   = !full;
  assign st_ade     = st_valid && fmt_misaligned;
  // Rejected (misaligned or unknown op) stores are consumed but never queued.
  assign push       = st_valid && st_ready && fmt_legal && !fmt_misaligned;
  assign issue      = !fifo_empty && (outstanding < FULL_CNT);
  assign pop        = issue && bus.addr_ok;
  assign retire     = bus.data_ok && (outstanding != '0);
  assign head       = mem[rd_ptr];
  assign st_empty   = fifo_empty && (outstanding == '0);

  // Fields are zeroed while idle so the bus never shows stale or unwritten slots.
  assign bus.req   = issue;
  assign bus.wr    = 1'b1;
  assign bus.addr  = issue ? head.addr  : '0;
  assign bus.wstrb = issue ? head.wstrb : '0;
  assign bus.wdata = issue ? head.wdata : '0;
  assign bus.size  = issue ? head.size  : '0;

  // NOTE: the storage array is not reset; count/pointers alone decide which slots are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fmt_req;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      case ({pop, retire})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: ;
      endcase
    end
  end

endmodule
